fp_add_reg: RTL and testbench



---
 rtl/fp_ieee754_pkg.sv | 43 ++++
 rtl/fp_class.sv | 51 +++++
 rtl/fp_add_reg.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_add_reg.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ieee754_pkg.sv
// Shared IEEE-754 constants for the adder: rounding-mode, class and exception bit indices,
// plus the rounding-mode decoder.
package fp_ieee754_pkg;

    localparam int unsigned NRAS   = 5;
    localparam int unsigned NTYPES = 6;
    localparam int unsigned NEXC   = 5;

    localparam int unsigned RaRne = 0;
    localparam int unsigned RaRtz = 1;
    localparam int unsigned RaRtp = 2;
    localparam int unsigned RaRtn = 3;
    localparam int unsigned RaRta = 4;

    localparam int unsigned ClsSnan      = 0;
    localparam int unsigned ClsQnan      = 1;
    localparam int unsigned ClsInf       = 2;
    localparam int unsigned ClsZero      = 3;
    localparam int unsigned ClsNormal    = 4;
    localparam int unsigned ClsSubnormal = 5;

    localparam int unsigned ExcInvalid   = 0;
    localparam int unsigned ExcDivZero   = 1;
    localparam int unsigned ExcOverflow  = 2;
    localparam int unsigned ExcUnderflow = 3;
    localparam int unsigned ExcInexact   = 4;

    typedef enum logic [2:0] {RndRne, RndRtz, RndRtp, RndRtn, RndRta} rnd_e;

    // Anything that is not exactly one-hot falls back to ties-to-even.
    function automatic rnd_e decode_ra(input logic [NRAS-1:0] ra);
        rnd_e mode;
        unique case (ra)
            NRAS'(1 << RaRtz): mode = RndRtz;
            NRAS'(1 << RaRtp): mode = RndRtp;
            NRAS'(1 << RaRtn): mode = RndRtn;
            NRAS'(1 << RaRta): mode = RndRta;
            default:           mode = RndRne;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/fp_class.sv
// Splits one IEEE-754 word into sign, effective exponent and significand (hidden bit
// included) and reports its one-hot class.
module fp_class
    import fp_ieee754_pkg::*;
#(
    parameter int unsigned NEXP = 5,
    parameter int unsigned NSIG = 10
) (
    input  logic [NEXP+NSIG:0]  op_i,
    output logic                sign_o,
    output logic [NEXP-1:0]     exp_o,
    output logic [NSIG:0]       sig_o,
    output logic                zero_o,
    output logic                inf_o,
    output logic                nan_o,
    output logic                snan_o,
    output logic [NTYPES-1:0]   flags_o
);

    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    logic            e_zero;
    logic            e_ones;
    logic            f_zero;

    assign e      = op_i[NEXP+NSIG-1:NSIG];
    assign f      = op_i[NSIG-1:0];
    assign e_zero = (e == '0);
    assign e_ones = &e;
    assign f_zero = (f == '0);

    assign sign_o = op_i[NEXP+NSIG];
    // Subnormals share the minimum normal exponent so alignment needs no special case.
    assign exp_o  = e_zero ? NEXP'(1) : e;
    assign sig_o  = {~e_zero, f};
    assign zero_o = e_zero & f_zero;
    assign inf_o  = e_ones & f_zero;
    assign nan_o  = e_ones & ~f_zero;
    assign snan_o = nan_o & ~f[NSIG-1];

    always_comb begin
        flags_o               = '0;
        flags_o[ClsSnan]      = snan_o;
        flags_o[ClsQnan]      = nan_o & f[NSIG-1];
        flags_o[ClsInf]       = inf_o;
        flags_o[ClsZero]      = zero_o;
        flags_o[ClsNormal]    = ~e_zero & ~e_ones;
        flags_o[ClsSubnormal] = e_zero & ~f_zero;
    end

endmodule

// File: rtl/fp_add_reg.sv
// Registered IEEE-754 adder with guard/round/sticky rounding, one cycle latency.
// Define FP_ADD_STICKY_EXC_EN to add the accumulated exc_sticky output.
module fp_add_reg
    import fp_ieee754_pkg::*;
#(
    parameter  int unsigned NEXP = 5,
    parameter  int unsigned NSIG = 10,
    localparam int unsigned W    = NEXP + NSIG + 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [NRAS-1:0]   ra,
    output logic              out_valid,
    output logic [W-1:0]      s,
    output logic [NTYPES-1:0] s_flags,
    output logic [NEXC-1:0]   exception
`ifdef FP_ADD_STICKY_EXC_EN
    ,
    output logic [NEXC-1:0]   exc_sticky
`endif
);

    localparam int unsigned XW  = NSIG + 4;
    localparam int unsigned SAT = NSIG + 3;
    localparam int unsigned SHW = $clog2(XW + 1) + 1;
    localparam logic [NEXP:0]  ExpOnes  = {1'b0, {NEXP{1'b1}}};
    localparam logic [W-1:0]   QuietBit = W'(1) << (NSIG - 1);
    localparam logic [W-1:0]   DefNan   = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    logic              a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic [NEXP-1:0]   a_exp, b_exp;
    logic [NSIG:0]     a_sig, b_sig;
    logic [NTYPES-1:0] a_flags, b_flags;

    fp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_cls_a (
        .op_i    (a),
        .sign_o  (a_sign),
        .exp_o   (a_exp),
        .sig_o   (a_sig),
        .zero_o  (a_zero),
        .inf_o   (a_inf),
        .nan_o   (a_nan),
        .snan_o  (a_snan),
        .flags_o (a_flags)
    );

    fp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_cls_b (
        .op_i    (b),
        .sign_o  (b_sign),
        .exp_o   (b_exp),
        .sig_o   (b_sig),
        .zero_o  (b_zero),
        .inf_o   (b_inf),
        .nan_o   (b_nan),
        .snan_o  (b_snan),
        .flags_o (b_flags)
    );

    // Order operands by magnitude; the larger one fixes the result sign and exponent.
    logic            a_ge, x_sign, eff_sub;
    logic [NEXP-1:0] x_exp, y_exp;
    logic [NSIG:0]   x_sig, y_sig;

    assign a_ge    = (a[W-2:0] >= b[W-2:0]);
    assign x_sign  = a_ge ? a_sign : b_sign;
    assign x_exp   = a_ge ? a_exp : b_exp;
    assign y_exp   = a_ge ? b_exp : a_exp;
    assign x_sig   = a_ge ? a_sig : b_sig;
    assign y_sig   = a_ge ? b_sig : a_sig;
    assign eff_sub = a_sign ^ b_sign;

    logic [NEXP-1:0] exp_diff;
    logic [SHW-1:0]  shamt;
    logic [XW-1:0]   x_ext, y_ext, y_al;
    logic [XW:0]     sum;

    always_comb begin
        exp_diff = x_exp - y_exp;
        shamt    = (32'(exp_diff) >= 32'(SAT)) ? SHW'(SAT) : SHW'(exp_diff);
        x_ext    = {x_sig, 3'b000};
        y_ext    = {y_sig, 3'b000};
        y_al     = (y_ext >> shamt) | XW'(|(y_ext & ~({XW{1'b1}} << shamt)));
        sum      = eff_sub ? ({1'b0, x_ext} - {1'b0, y_al}) : ({1'b0, x_ext} + {1'b0, y_al});
    end

    logic [SHW-1:0]  lz, lshift;
    logic [NEXP-1:0] lim;
    logic [XW-1:0]   norm;
    logic [NEXP:0]   norm_exp;

    always_comb begin
        lz = SHW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (sum[i]) lz = SHW'(XW - 1 - i);
        end
        // Left shift stops at the minimum exponent, leaving a subnormal pattern.
        lim    = x_exp - NEXP'(1);
        lshift = (32'(lz) > 32'(lim)) ? SHW'(lim) : lz;
        if (sum[XW]) begin
            norm     = {sum[XW:2], sum[1] | sum[0]};
            norm_exp = {1'b0, x_exp} + (NEXP+1)'(1);
        end else begin
            norm     = sum[XW-1:0] << lshift;
            norm_exp = {1'b0, x_exp} - (NEXP+1)'(lshift);
        end
    end

    rnd_e            rnd;
    logic            lsb, grd, stk, inexact, up, rnd_hid, ovf, ovf_to_inf;
    logic [NSIG+1:0] mant;
    logic [NEXP:0]   rnd_exp;
    logic [NSIG-1:0] rnd_frac;

    always_comb begin
        rnd     = decode_ra(ra);
        lsb     = norm[3];
        grd     = norm[2];
        stk     = |norm[1:0];
        inexact = grd | stk;
        unique case (rnd)
            RndRne:  up = grd & (stk | lsb);
            RndRtz:  up = 1'b0;
            RndRtp:  up = inexact & ~x_sign;
            RndRtn:  up = inexact & x_sign;
            RndRta:  up = grd;
            default: up = 1'b0;
        endcase
        mant = {1'b0, norm[XW-1:3]} + (NSIG+2)'(up);
        if (mant[NSIG+1]) begin
            rnd_exp  = norm_exp + (NEXP+1)'(1);
            rnd_frac = '0;
            rnd_hid  = 1'b1;
        end else begin
            rnd_exp  = norm_exp;
            rnd_frac = mant[NSIG-1:0];
            rnd_hid  = mant[NSIG];
        end
        ovf        = (rnd_exp >= ExpOnes);
        ovf_to_inf = (rnd == RndRne) | (rnd == RndRta) | ((rnd == RndRtp) & ~x_sign) |
                     ((rnd == RndRtn) & x_sign);
    end

    logic [W-1:0]    s_d;
    logic [NEXC-1:0] exc_d;

    always_comb begin
        s_d   = '0;
        exc_d = '0;
        if (a_nan | b_nan) begin
            s_d               = a_nan ? (a | QuietBit) : (b | QuietBit);
            exc_d[ExcInvalid] = a_snan | b_snan;
        end else if (a_inf & b_inf & eff_sub) begin
            s_d               = DefNan;
            exc_d[ExcInvalid] = 1'b1;
        end else if (a_inf) begin
            s_d = a;
        end else if (b_inf) begin
            s_d = b;
        end else if (sum == '0) begin
            s_d = {eff_sub ? (rnd == RndRtn) : a_sign, {(W-1){1'b0}}};
        end else if (ovf) begin
            s_d = ovf_to_inf ? {x_sign, {NEXP{1'b1}}, {NSIG{1'b0}}}
                             : {x_sign, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
            exc_d[ExcOverflow] = 1'b1;
            exc_d[ExcInexact]  = 1'b1;
        end else begin
            s_d = {x_sign, rnd_hid ? rnd_exp[NEXP-1:0] : {NEXP{1'b0}}, rnd_frac};
            exc_d[ExcInexact]   = inexact;
            exc_d[ExcUnderflow] = inexact & ~rnd_hid;
        end
    end

    logic              s_sign, s_zero, s_inf, s_nan, s_snan;
    logic [NEXP-1:0]   s_exp;
    logic [NSIG:0]     s_sig;
    logic [NTYPES-1:0] s_flags_d;

    fp_class #(.NEXP(NEXP), .NSIG(NSIG)) u_cls_s (
        .op_i    (s_d),
        .sign_o  (s_sign),
        .exp_o   (s_exp),
        .sig_o   (s_sig),
        .zero_o  (s_zero),
        .inf_o   (s_inf),
        .nan_o   (s_nan),
        .snan_o  (s_snan),
        .flags_o (s_flags_d)
    );

    logic unused_cls;
    assign unused_cls = ^{a_zero, b_zero, a_flags, b_flags, s_sign, s_zero, s_inf, s_nan,
                          s_snan, s_exp, s_sig};

    logic              out_valid_q;
    logic [W-1:0]      s_q;
    logic [NTYPES-1:0] s_flags_q;
    logic [NEXC-1:0]   exc_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            s_flags_q   <= '0;
            exc_q       <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                s_q       <= s_d;
                s_flags_q <= s_flags_d;
                exc_q     <= exc_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign s_flags   = s_flags_q;
    assign exception = exc_q;

`ifdef FP_ADD_STICKY_EXC_EN
    logic [NEXC-1:0] exc_sticky_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            exc_sticky_q <= '0;
        end else if (in_valid) begin
            exc_sticky_q <= exc_sticky_q | exc_d;
        end
    end

    assign exc_sticky = exc_sticky_q;
`endif

endmodule

// File: tb/tb_fp_add_reg.sv
// Self-checking bench for fp_add_reg (binary16): directed corner cases plus random
// operands checked against an exact-integer reference adder.
module tb_fp_add_reg;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        in_valid;
    logic [15:0] a, b;
    logic [4:0]  ra;
    logic        out_valid;
    logic [15:0] s;
    logic [5:0]  s_flags;
    logic [4:0]  exception;
`ifdef FP_ADD_STICKY_EXC_EN
    logic [4:0]  exc_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_reg dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ra        (ra),
        .out_valid (out_valid),
        .s         (s),
        .s_flags   (s_flags),
        .exception (exception)
`ifdef FP_ADD_STICKY_EXC_EN
        ,
        .exc_sticky (exc_sticky)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Finite operand as an exact signed integer in units of the smallest subnormal (2^-24).
    function automatic longint fin_val(input logic [15:0] x);
        longint m;
        int     e;
        m = (x[14:10] != 5'd0) ? longint'({1'b1, x[9:0]}) : longint'(x[9:0]);
        e = (x[14:10] != 5'd0) ? int'(x[14:10]) : 1;
        m = m << (e - 1);
        return x[15] ? -m : m;
    endfunction

    function automatic logic [5:0] ref_class(input logic [15:0] x);
        logic [5:0] c;
        c = 6'h00;
        if (x[14:10] == 5'h1f) c = (x[9:0] == 10'd0) ? 6'h04 : (x[9] ? 6'h02 : 6'h01);
        else if (x[14:10] != 5'd0) c = 6'h10;
        else c = (x[9:0] == 10'd0) ? 6'h08 : 6'h20;
        return c;
    endfunction

    function automatic void ref_add(input logic [15:0] x, input logic [15:0] y,
                                    input logic [4:0] rm, output logic [15:0] rs,
                                    output logic [4:0] rx);
        int          mode, msb, k, fld;
        logic        xn, yn, xsn, ysn, xi, yi, neg, up;
        longint      sum;
        logic [63:0] mm, q, r, half;
        mode = 0;
        if ($onehot(rm)) for (int i = 0; i < 5; i++) if (rm[i]) mode = i;
        xn  = (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
        yn  = (y[14:10] == 5'h1f) && (y[9:0] != 10'd0);
        xsn = xn && !x[9];
        ysn = yn && !y[9];
        xi  = (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
        yi  = (y[14:10] == 5'h1f) && (y[9:0] == 10'd0);
        rx  = 5'h00;
        rs  = 16'h0000;
        if (xn || yn) begin
            rs = xn ? (x | 16'h0200) : (y | 16'h0200);
            rx = (xsn || ysn) ? 5'h01 : 5'h00;
            return;
        end
        if (xi && yi && (x[15] != y[15])) begin
            rs = 16'h7E00;
            rx = 5'h01;
            return;
        end
        if (xi) begin rs = x; return; end
        if (yi) begin rs = y; return; end
        sum = fin_val(x) + fin_val(y);
        if (sum == 0) begin
            rs = {(x[15] != y[15]) ? (mode == 3) : x[15], 15'h0000};
            return;
        end
        neg = (sum < 0);
        mm  = neg ? 64'(-sum) : 64'(sum);
        msb = 0;
        for (int i = 0; i < 64; i++) if (mm[i]) msb = i;
        k    = (msb > 10) ? msb - 10 : 0;
        q    = mm >> k;
        r    = mm & ((64'd1 << k) - 64'd1);
        half = (k > 0) ? (64'd1 << (k - 1)) : 64'd0;
        case (mode)
            0:       up = (k > 0) && ((r > half) || ((r == half) && q[0]));
            2:       up = (r != 0) && !neg;
            3:       up = (r != 0) && neg;
            4:       up = (k > 0) && (r >= half);
            default: up = 1'b0;
        endcase
        if (up) q = q + 64'd1;
        if (q == 64'd2048) begin
            q = 64'd1024;
            k = k + 1;
        end
        fld = (q >= 64'd1024) ? k + 1 : 0;
        if (fld >= 31) begin
            rx = 5'h14;
            if (mode == 0 || mode == 4 || (mode == 2 && !neg) || (mode == 3 && neg))
                rs = {neg, 5'h1f, 10'h000};
            else
                rs = {neg, 5'h1e, 10'h3ff};
            return;
        end
        rs = {neg, fld[4:0], q[9:0]};
        if (r != 0) rx[4] = 1'b1;
        if (r != 0 && fld == 0) rx[3] = 1'b1;
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  ra;
        logic [15:0] s;
        logic [5:0]  fl;
        logic [4:0]  ex;
    } vec_t;

    vec_t dirs [19];

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [4:0] tra);
        a        = ta;
        b        = tb;
        ra       = tra;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       v[14:10] = 5'h1f;
            1:       v[14:10] = 5'h00;
            2:       v[14:10] = 5'(29 + $urandom_range(0, 1));
            3:       v[9:0]   = 10'h3ff;
            default: ;
        endcase
        return v;
    endfunction

    logic [15:0] ea, eb, es;
    logic [4:0]  era, ex;
    logic [4:0]  sticky_ref;

    initial begin
        dirs = '{
            '{16'h3C00, 16'h3C00, 5'h01, 16'h4000, 6'h10, 5'h00},
            '{16'h7BFF, 16'h7BFF, 5'h01, 16'h7C00, 6'h04, 5'h14},
            '{16'h7BFF, 16'h7BFF, 5'h02, 16'h7BFF, 6'h10, 5'h14},
            '{16'hFBFF, 16'hFBFF, 5'h08, 16'hFC00, 6'h04, 5'h14},
            '{16'h3C00, 16'h1000, 5'h01, 16'h3C00, 6'h10, 5'h10},
            '{16'h3C00, 16'h1000, 5'h10, 16'h3C01, 6'h10, 5'h10},
            '{16'h3C00, 16'h1000, 5'h04, 16'h3C01, 6'h10, 5'h10},
            '{16'h3C00, 16'h1000, 5'h02, 16'h3C00, 6'h10, 5'h10},
            '{16'h7C00, 16'hFC00, 5'h01, 16'h7E00, 6'h02, 5'h01},
            '{16'h7D00, 16'h3C00, 5'h01, 16'h7F00, 6'h02, 5'h01},
            '{16'h7E01, 16'h7D00, 5'h01, 16'h7E01, 6'h02, 5'h01},
            '{16'h3C00, 16'hBC00, 5'h01, 16'h0000, 6'h08, 5'h00},
            '{16'h3C00, 16'hBC00, 5'h08, 16'h8000, 6'h08, 5'h00},
            '{16'h8000, 16'h8000, 5'h01, 16'h8000, 6'h08, 5'h00},
            '{16'h0001, 16'h0001, 5'h01, 16'h0002, 6'h20, 5'h00},
            '{16'h3C00, 16'h1000, 5'h03, 16'h3C00, 6'h10, 5'h10},
            '{16'h0000, 16'h8000, 5'h08, 16'h8000, 6'h08, 5'h00},
            '{16'h7C00, 16'h3C00, 5'h01, 16'h7C00, 6'h04, 5'h00},
            '{16'h0400, 16'h8001, 5'h01, 16'h03FF, 6'h20, 5'h00}
        };

        clr_n      = 1'b0;
        in_valid   = 1'b0;
        a          = 16'h0000;
        b          = 16'h0000;
        ra         = 5'h01;
        sticky_ref = 5'h00;
        #22;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_s", 32'(s), 32'd0);
        check_eq("rst_flags", 32'(s_flags), 32'd0);
        check_eq("rst_exc", 32'(exception), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (dirs[i]) begin
            run_op(dirs[i].a, dirs[i].b, dirs[i].ra);
            sticky_ref |= dirs[i].ex;
            check_eq($sformatf("dir%0d_valid", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("dir%0d_s", i), 32'(s), 32'(dirs[i].s));
            check_eq($sformatf("dir%0d_flags", i), 32'(s_flags), 32'(dirs[i].fl));
            check_eq($sformatf("dir%0d_exc", i), 32'(exception), 32'(dirs[i].ex));
        end

        // Idle cycle must hold the last result.
        in_valid = 1'b0;
        a        = 16'h7BFF;
        b        = 16'h7BFF;
        @(posedge clk);
        #1;
        check_eq("hold_valid", 32'(out_valid), 32'd0);
        check_eq("hold_s", 32'(s), 32'h0000_03FF);
        check_eq("hold_flags", 32'(s_flags), 32'h20);

        // Asynchronous reset in the middle of a stream drops the pending result.
        run_op(16'h3C00, 16'h3C00, 5'h01);
        a = 16'h7BFF;
        b = 16'h7BFF;
        #2;
        clr_n = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_s", 32'(s), 32'd0);
        check_eq("mrst_exc", 32'(exception), 32'd0);
        sticky_ref = 5'h00;
        in_valid   = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mrst_hold_s", 32'(s), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 4000; n++) begin
            ea = rand_op();
            case ($urandom_range(0, 3))
                0:       eb = {1'($urandom), 5'(ea[14:10] + 5'($urandom_range(0, 2))), 10'($urandom)};
                1:       eb = ea ^ 16'h8000;
                default: eb = rand_op();
            endcase
            era = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
            ref_add(ea, eb, era, es, ex);
            sticky_ref |= ex;
            run_op(ea, eb, era);
            check_eq($sformatf("rnd_s %h+%h ra=%b", ea, eb, era), 32'(s), 32'(es));
            check_eq($sformatf("rnd_flags %h+%h ra=%b", ea, eb, era), 32'(s_flags),
                     32'(ref_class(es)));
            check_eq($sformatf("rnd_exc %h+%h ra=%b", ea, eb, era), 32'(exception), 32'(ex));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
`ifdef FP_ADD_STICKY_EXC_EN
        check_eq("sticky", 32'(exc_sticky), 32'(sticky_ref));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
